register_read_responder: RTL

//   Read-side companion to the team's write-enable register primitive.

---
 rtl/register_read_responder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/register_read_responder.sv
// register_read_responder: takes one read address per request over an AR-style
// valid/ready channel and returns the selected register word from a flattened bank.
// The word comes back over an R-style valid/ready channel with an OKAY or SLVERR response.
// It also pulses a one-hot read strobe in the first response cycle, so upstream
// logic can implement clear-on-read.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   araddr/arvalid/arready    read address channel (word address)
//   rdata/rresp/rvalid/rready read response channel (2'b00 OKAY, 2'b10 SLVERR)
//   regs_i                    register bank, word i at regs_i[i*WIDTH +: WIDTH]
//   read_strobe_o             one-hot, single-cycle pulse per accepted in-range read
//
// Timing: the data is sampled on the acceptance edge, and rvalid is high in the next cycle.
// With rready held high, each read takes two cycles.
// Backpressure: while rvalid is high and rready is low, the response is held stable.
// arready stays low until the response handshake completes.
// The bank must fit the address space: 2**ADDR_WIDTH >= NUM_REGS.
module register_read_responder #(
  parameter int NUM_REGS   = 8,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [WIDTH-1:0]          rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  input  logic [NUM_REGS*WIDTH-1:0] regs_i,
  output logic [NUM_REGS-1:0]       read_strobe_o
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e                state_q,   state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q,  rvalid_d;
  logic [WIDTH-1:0]      rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;
  logic [NUM_REGS-1:0]   strobe_q,  strobe_d;

  // Address decode. The loop only visits implemented registers, so an
  // out-of-range address matches nothing. That gives a zero word, an empty
  // strobe vector and in_range=0, with no out-of-bounds part-selects.
  logic [WIDTH-1:0]      word_sel;
  logic [NUM_REGS-1:0]   hit_vec;
  logic                  in_range;

  always_comb begin
    word_sel = '0;
    hit_vec  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (araddr == i[ADDR_WIDTH-1:0]) begin
        word_sel   = regs_i[i*WIDTH +: WIDTH];
        hit_vec[i] = 1'b1;
      end
    end
    in_range = |hit_vec;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    // The strobe is a single-cycle pulse. It is only ever set on the acceptance
    // edge, so it is low again in the second response cycle.
    strobe_d  = '0;

    unique case (state_q)
      IDLE: begin
        // arready rises on the first edge seen with reset low.
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          rdata_d   = word_sel;
          rresp_d   = in_range ? RESP_OKAY : RESP_SLVERR;
          strobe_d  = hit_vec;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          state_d   = RESP;
        end
      end

      RESP: begin
        // araddr, arvalid and regs_i are ignored here.
        // rdata and rresp hold until the handshake.
        if (rvalid_q && rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      strobe_q  <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;   // not cleared after handshake
      rresp_q   <= rresp_d;
      strobe_q  <= strobe_d;
    end
  end

  assign arready       = arready_q;
  assign rvalid        = rvalid_q;
  assign rdata         = rdata_q;
  assign rresp         = rresp_q;
  assign read_strobe_o = strobe_q;

endmodule
